vga_scanout: RTL and testbench

Parametrised VGA scan-out engine: generates horizontal/vertical timing from a divided pixel tick, fetches pixels from a synchronous-read framebuffer with power-of-two upscaling, and drives RGB, sync and data-enable with equal pipeline delay. Sits between the framebuffer's read port and the VGA pins. Replaces the fixed 640x400, ÷4, ×4-scale timing logic in the top level.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_scanout_if.sv | 28 ++
 rtl/vga_scan_counters.sv | 43 ++++
 rtl/vga_scanout.sv | 154 +++++++++++++++
 tb/tb_vga_scanout.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA scan-out slice: default 640x400 timing, RGB332 layout,
// the per-pixel side-band flags carried alongside the fetch, and the test-bar colour mapping.
package vga_pkg;

    localparam int CNT_W        = 15;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 400;
    localparam int DEF_V_FP     = 11;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 32;

    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } pix_meta_t;

    // Bar index bits fan out to fill each RGB332 field, giving black..white in 8 steps.
    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        return {{R_W{idx[2]}}, {G_W{idx[1]}}, {B_W{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus VGA pin bundle; master is the scan-out engine.
interface vga_scanout_if
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int PIX_WIDTH  = RGB_W
);
    logic [ADDR_WIDTH-1:0] fb_addr;
    logic [PIX_WIDTH-1:0]  fb_rdata;
    logic [PIX_WIDTH-1:0]  rgb;
    logic                  hsync;
    logic                  vsync;
    logic                  de;
    logic                  line_start;
    logic                  frame_start;

    modport master (
        output fb_addr,
        input  fb_rdata,
        output rgb, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        input  fb_addr,
        output fb_rdata,
        input  rgb, hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_scan_counters.sv
// Pixel-tick divider and raster position counters; tick fires in the last clock of each pixel.
module vga_scan_counters
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 445
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div  <= '0;
            hpos <= '0;
            vpos <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (hpos == H_LAST) begin
                    hpos <= '0;
                    vpos <= (vpos == V_LAST) ? '0 : vpos + 1'b1;
                end else begin
                    hpos <= hpos + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: framebuffer fetch with 2^S upscaling; rgb/sync/de land 2 ticks after the counters.
// No backpressure. Defining VGA_TEST_PATTERN_EN adds a test_mode input selecting 8 colour bars.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int SCALE_LOG2  = 2,
    parameter int ADDR_H_BITS = 8,
    parameter int ADDR_V_BITS = 7,
    parameter int PIX_WIDTH   = RGB_W,
    parameter int RD_LATENCY  = 1
) (
    input  logic          clk,
    input  logic          reset,
    vga_scanout_if.master bus
`ifdef VGA_TEST_PATTERN_EN
    ,
    input  logic          test_mode
`endif
);

    localparam int ADDR_WIDTH = ADDR_H_BITS + ADDR_V_BITS;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Read data is sampled one full tick after the address register, so the RAM must settle within it.
    if (CLK_DIV < RD_LATENCY + 1) begin : g_bad_div
        $error("vga_scanout: CLK_DIV must be at least RD_LATENCY+1");
    end
    if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_total
        $error("vga_scanout: H_TOTAL/V_TOTAL exceed the position counter width");
    end
    if ((H_ACTIVE >> SCALE_LOG2) > (1 << ADDR_H_BITS)) begin : g_bad_h_addr
        $error("vga_scanout: scaled H_ACTIVE does not fit ADDR_H_BITS");
    end
    if ((V_ACTIVE >> SCALE_LOG2) > (1 << ADDR_V_BITS)) begin : g_bad_v_addr
        $error("vga_scanout: scaled V_ACTIVE does not fit ADDR_V_BITS");
    end

    logic             tick;
    logic [CNT_W-1:0] hpos;
    logic [CNT_W-1:0] vpos;

    vga_scan_counters #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counters (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .hpos  (hpos),
        .vpos  (vpos)
    );

    pix_meta_t             s1;
    logic [ADDR_WIDTH-1:0] fb_addr_q;
    logic [PIX_WIDTH-1:0]  pix_next;
    logic [PIX_WIDTH-1:0]  rgb_q;
    logic                  de_q;
    logic                  hsync_q;
    logic                  vsync_q;
    logic                  line_q;
    logic                  frame_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_ACTIVE / 8);

    if (PIX_WIDTH != RGB_W || H_ACTIVE < 8) begin : g_bad_bars
        $error("vga_scanout: colour bars need an RGB332 pixel and H_ACTIVE >= 8");
    end

    logic [CNT_W-1:0] hpos1;

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos1 <= '0;
        end else if (tick) begin
            hpos1 <= hpos;
        end
    end

    always_comb begin
        pix_next = '0;
        if (s1.act) begin
            pix_next = test_mode ? PIX_WIDTH'(bar_colour(3'(hpos1 / BAR_W_C))) : bus.fb_rdata;
        end
    end
`else
    always_comb begin
        pix_next = '0;
        if (s1.act) begin
            pix_next = bus.fb_rdata;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            fb_addr_q <= '0;
            rgb_q     <= '0;
            de_q      <= 1'b0;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            if (tick) begin
                fb_addr_q <= {ADDR_V_BITS'(vpos >> SCALE_LOG2), ADDR_H_BITS'(hpos >> SCALE_LOG2)};
                s1.act    <= (hpos < H_ACT_C) && (vpos < V_ACT_C);
                s1.hs     <= (hpos >= HS_START) && (hpos < HS_END);
                s1.vs     <= (vpos >= VS_START) && (vpos < VS_END);
                s1.ls     <= (hpos == '0);
                s1.fs     <= (hpos == '0) && (vpos == '0);

                rgb_q     <= pix_next;
                de_q      <= s1.act;
                hsync_q   <= s1.hs ? HSYNC_POL : ~HSYNC_POL;
                vsync_q   <= s1.vs ? VSYNC_POL : ~VSYNC_POL;
                line_q    <= s1.ls;
                frame_q   <= s1.fs;
            end
        end
    end

    assign bus.fb_addr     = fb_addr_q;
    assign bus.rgb         = rgb_q;
    assign bus.de          = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.line_start  = line_q;
    assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken 24x16 raster; outputs are predicted from the clock count since reset.
module tb_vga_scanout;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam bit H_POL    = 1'b0;
    localparam bit V_POL    = 1'b1;
    localparam int S        = 1;
    localparam int AHB      = 8;
    localparam int AVB      = 7;
    localparam int AW       = AHB + AVB;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic test_mode = 1'b0;
    int   n         = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    vga_scanout_if #(.ADDR_WIDTH(AW), .PIX_WIDTH(8)) bus ();

    vga_scanout #(
        .CLK_DIV     (CLK_DIV),
        .H_ACTIVE    (H_ACTIVE),
        .H_FP        (H_FP),
        .H_SYNC      (H_SYNC),
        .H_BP        (H_BP),
        .V_ACTIVE    (V_ACTIVE),
        .V_FP        (V_FP),
        .V_SYNC      (V_SYNC),
        .V_BP        (V_BP),
        .HSYNC_POL   (H_POL),
        .VSYNC_POL   (V_POL),
        .SCALE_LOG2  (S),
        .ADDR_H_BITS (AHB),
        .ADDR_V_BITS (AVB),
        .PIX_WIDTH   (8),
        .RD_LATENCY  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .test_mode (test_mode)
`endif
    );

    function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
        return a[7:0] + 8'(a[AW-1:AHB]) * 8'd3;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int h, input int v);
        return {7'(v >> S), 8'(h >> S)};
    endfunction

    function automatic logic [7:0] bar_of(input int h);
        logic [2:0] i;
        i = 3'(h / (H_ACTIVE / 8));
        return {{3{i[2]}}, {3{i[1]}}, {2{i[0]}}};
    endfunction

    // Synchronous-read framebuffer, one clock of latency.
    always @(posedge clk) bus.fb_rdata <= mem_f(bus.fb_addr);

    always @(posedge clk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at clk %0d: got 0x%0h expected 0x%0h", nm, n, act, exp);
        end
    endtask

    // Ticks occur every CLK_DIV clocks after release; tick t registers pixel t-1 and shows pixel t-2.
    always @(negedge clk) begin : cmp
        int t, q, h, v;
        logic [31:0] e_addr, e_rgb;
        logic e_de, e_hs, e_vs, e_ls, e_fs;
        t = n / CLK_DIV;
        e_addr = '0; e_rgb = '0; e_de = 1'b0;
        e_hs = !H_POL; e_vs = !V_POL; e_ls = 1'b0; e_fs = 1'b0;
        if (t >= 1) begin
            q = t - 1;
            e_addr = 32'(addr_of(q % H_TOTAL, (q / H_TOTAL) % V_TOTAL));
        end
        if (t >= 2) begin
            q = t - 2;
            h = q % H_TOTAL;
            v = (q / H_TOTAL) % V_TOTAL;
            e_de = (h < H_ACTIVE) && (v < V_ACTIVE);
            if (e_de) e_rgb = test_mode ? 32'(bar_of(h)) : 32'(mem_f(addr_of(h, v)));
            e_hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? H_POL : !H_POL;
            e_vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? V_POL : !V_POL;
            e_ls = (n % CLK_DIV == 0) && (h == 0);
            e_fs = e_ls && (v == 0);
        end
        check("fb_addr", 32'(bus.fb_addr), e_addr);
        check("rgb", 32'(bus.rgb), e_rgb);
        check("de", 32'(bus.de), 32'(e_de));
        check("hsync", 32'(bus.hsync), 32'(e_hs));
        check("vsync", 32'(bus.vsync), 32'(e_vs));
        check("line_start", 32'(bus.line_start), 32'(e_ls));
        check("frame_start", 32'(bus.frame_start), 32'(e_fs));

        if (n == 4)   check("lit_first_frame_start", 32'(bus.frame_start), 32'd1);
        if (n == 38)  check("lit_hsync_idle_h17", 32'(bus.hsync), 32'd1);
        if (n == 40)  check("lit_hsync_active_h18", 32'(bus.hsync), 32'd0);
        if (n == 52)  check("lit_line_start_line1", 32'(bus.line_start), 32'd1);
        if (n == 626) check("lit_vsync_idle_v12", 32'(bus.vsync), 32'd0);
        if (n == 628) check("lit_vsync_active_v13", 32'(bus.vsync), 32'd1);
        if (n == 772) check("lit_second_frame_start", 32'(bus.frame_start), 32'd1);
        if (n == 462 && !test_mode) begin
            check("lit_rgb_h13_v9", 32'(bus.rgb), 32'd18);
            check("lit_fb_addr_h14_v9", 32'(bus.fb_addr), 32'd1031);
        end
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode && n == 4)  check("lit_bar0", 32'(bus.rgb), 32'h00);
        if (test_mode && n == 8)  check("lit_bar1", 32'(bus.rgb), 32'h03);
        if (test_mode && n == 34) check("lit_bar7", 32'(bus.rgb), 32'hFF);
`endif
    end

    initial begin
        reset = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (1700) @(negedge clk);

        // One-clock reset in the middle of an active line.
        reset = 1'b1;
        @(negedge clk);
        check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
        check("rst_rgb", 32'(bus.rgb), 32'd0);
        check("rst_de", 32'(bus.de), 32'd0);
        check("rst_hsync", 32'(bus.hsync), 32'd1);
        check("rst_vsync", 32'(bus.vsync), 32'd0);
        check("rst_pulses", 32'({bus.line_start, bus.frame_start}), 32'd0);
        reset = 1'b0;
        repeat (900) @(negedge clk);

`ifdef VGA_TEST_PATTERN_EN
        reset = 1'b1;
        @(negedge clk);
        test_mode = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (800) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
